alu_request_arbiter: RTL and testbench

Shares one 4-bit ALU datapath (arithmetic/logic/compare units plus output muxes, selected by a 4-bit S code) between two requesters. Round-robin arbitration, valid/ready handshake on each request port, operand/opcode registers driving the ALU, result capture after a fixed datapath latency, and a single response port tagged with the requester ID. Sits between the requesting control blocks and the ALU instance.

---
 rtl/alu_request_arbiter_pkg.sv | 14 +
 rtl/alu_rr_grant2.sv | 33 +++
 rtl/alu_request_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_request_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_request_arbiter_pkg.sv
// rtl/alu_request_arbiter_pkg.sv - shared widths and FSM encodings for the ALU request arbiter
package alu_request_arbiter_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int S_WIDTH   = 4;
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_rr_grant2.sv
// rtl/alu_rr_grant2.sv - two-way round-robin grant from request valids and priority pointer
module alu_rr_grant2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       grant_id
);

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        unique case (valid)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                grant    = ptr ? 2'b10 : 2'b01;
                grant_id = ptr;
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - round-robin sharing of one ALU datapath between two requesters
module alu_request_arbiter
    import alu_request_arbiter_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ0_VALID,
    output logic               REQ0_READY,
    input  logic [WIDTH-1:0]   REQ0_A,
    input  logic [WIDTH-1:0]   REQ0_B,
    input  logic [S_WIDTH-1:0] REQ0_S,
    input  logic               REQ1_VALID,
    output logic               REQ1_READY,
    input  logic [WIDTH-1:0]   REQ1_A,
    input  logic [WIDTH-1:0]   REQ1_B,
    input  logic [S_WIDTH-1:0] REQ1_S,
    output logic [WIDTH-1:0]   ALU_A,
    output logic [WIDTH-1:0]   ALU_B,
    output logic [S_WIDTH-1:0] ALU_S,
    input  logic [WIDTH-1:0]   ALU_F,
    input  logic               ALU_C_OUT,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic               RSP_ID,
    output logic [WIDTH-1:0]   RSP_F,
    output logic               RSP_C
);

    localparam logic [CNT_WIDTH-1:0] LAT_LOAD = CNT_WIDTH'(LATENCY);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic                 ptr_q;
    logic [1:0]           grant;
    logic                 grant_id;
    logic                 accept;
    logic                 capture;
    logic                 rsp_done;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [S_WIDTH-1:0]   s_q;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [WIDTH-1:0]     rsp_f_q;
    logic                 rsp_c_q;

    alu_rr_grant2 u_grant (
        .valid    ({REQ1_VALID, REQ0_VALID}),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are only offered in IDLE, so nothing is accepted while a result is pending.
    always_comb begin
        state_d    = state_q;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                REQ0_READY = grant[0];
                REQ1_READY = grant[1];
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_WIDTH'(1)) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers hold their value until the next accept so the ALU inputs stay quiet.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_f_q     <= '0;
            rsp_c_q     <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= grant_id ? REQ1_A : REQ0_A;
                b_q      <= grant_id ? REQ1_B : REQ0_B;
                s_q      <= grant_id ? REQ1_S : REQ0_S;
                rsp_id_q <= grant_id;
                cnt_q    <= LAT_LOAD;
                ptr_q    <= ~grant_id;
            end else if (state_q == EXEC) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (capture) begin
                rsp_f_q     <= ALU_F;
                rsp_c_q     <= ALU_C_OUT;
                rsp_valid_q <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign ALU_A     = a_q;
    assign ALU_B     = b_q;
    assign ALU_S     = s_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_F     = rsp_f_q;
    assign RSP_C     = rsp_c_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb/tb_alu_request_arbiter.sv - scoreboard bench for alu_request_arbiter
module tb_alu_request_arbiter;

    typedef struct packed {
        logic       id;
        logic [3:0] f;
        logic       c;
    } rsp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic       r0v, r0r, r1v, r1r;
    logic [3:0] r0a, r0b, r0s, r1a, r1b, r1s;
    logic [3:0] alu_a, alu_b, alu_s, alu_f;
    logic       alu_c;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_c;
    logic [3:0] rsp_f;

    logic       r0v_3, r0r_3, r1v_3, r1r_3;
    logic [3:0] r0a_3, r0b_3, r0s_3, r1a_3, r1b_3, r1s_3;
    logic [3:0] alu_a_3, alu_b_3, alu_s_3, alu_f_3;
    logic       alu_c_3;
    logic       rsp_valid_3, rsp_ready_3, rsp_id_3, rsp_c_3;
    logic [3:0] rsp_f_3;

    int   tests_run    = 0;
    int   tests_failed = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;
    logic ptr_m     = 1'b0;
    logic last_acc  = 1'b0;
    logic last_id   = 1'b0;

    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        case (s[1:0])
            2'd0:    alu_fn = {1'b0, a} + {1'b0, b};
            2'd1:    alu_fn = {1'b0, a} - {1'b0, b};
            2'd2:    alu_fn = {1'b0, a & b};
            default: alu_fn = {s[3], a ^ b};
        endcase
    endfunction

    assign {alu_c, alu_f} = alu_fn(alu_a, alu_b, alu_s);

    alu_request_arbiter #(.WIDTH(4), .LATENCY(1)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(r0v), .REQ0_READY(r0r), .REQ0_A(r0a), .REQ0_B(r0b), .REQ0_S(r0s),
        .REQ1_VALID(r1v), .REQ1_READY(r1r), .REQ1_A(r1a), .REQ1_B(r1b), .REQ1_S(r1s),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_S(alu_s), .ALU_F(alu_f), .ALU_C_OUT(alu_c),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id), .RSP_F(rsp_f), .RSP_C(rsp_c)
    );

    alu_request_arbiter #(.WIDTH(4), .LATENCY(3)) dut3 (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(r0v_3), .REQ0_READY(r0r_3), .REQ0_A(r0a_3), .REQ0_B(r0b_3), .REQ0_S(r0s_3),
        .REQ1_VALID(r1v_3), .REQ1_READY(r1r_3), .REQ1_A(r1a_3), .REQ1_B(r1b_3), .REQ1_S(r1s_3),
        .ALU_A(alu_a_3), .ALU_B(alu_b_3), .ALU_S(alu_s_3), .ALU_F(alu_f_3), .ALU_C_OUT(alu_c_3),
        .RSP_VALID(rsp_valid_3), .RSP_READY(rsp_ready_3), .RSP_ID(rsp_id_3), .RSP_F(rsp_f_3), .RSP_C(rsp_c_3)
    );

    // Response monitor: every completed handshake pops the oldest expected result.
    always @(negedge CLK) begin
        #2;
        if (!RST && rsp_valid && rsp_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp_unexpected: got id=%0d f=%h c=%0d with empty scoreboard", rsp_id, rsp_f, rsp_c);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_id, rsp_f, rsp_c} !== mon_e) begin
                    tests_failed++;
                    $display("FAIL rsp_data: got id=%0d f=%h c=%0d, expected id=%0d f=%h c=%0d",
                             rsp_id, rsp_f, rsp_c, mon_e.id, mon_e.f, mon_e.c);
                end
            end
        end
    end

    // One clock cycle of stimulus on the LATENCY=1 instance with grant checking against the pointer model.
    task automatic step(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] s0,
                        input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] s1,
                        input logic rr);
        logic [1:0] exp_g;
        rsp_t       e;
        @(negedge CLK);
        r0v = v0; r0a = a0; r0b = b0; r0s = s0;
        r1v = v1; r1a = a1; r1b = b1; r1s = s1;
        rsp_ready = rr;
        #1;
        tests_run++;
        if (r0r && r1r) begin
            tests_failed++;
            $display("FAIL ready_both: REQ0_READY=%0d REQ1_READY=%0d, expected not both high", r0r, r1r);
        end
        last_acc = r0r | r1r;
        if (last_acc) begin
            exp_g = (v0 && v1) ? (ptr_m ? 2'b10 : 2'b01) : {v1, v0};
            tests_run++;
            if ({r1r, r0r} !== exp_g) begin
                tests_failed++;
                $display("FAIL grant: READY={%0d,%0d}, expected {%0d,%0d}", r1r, r0r, exp_g[1], exp_g[0]);
            end
            last_id = exp_g[1];
            e.id = exp_g[1];
            if (exp_g[1]) {e.c, e.f} = alu_fn(a1, b1, s1);
            else          {e.c, e.f} = alu_fn(a0, b0, s0);
            exp_q.push_back(e);
            ptr_m = ~exp_g[1];
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    endtask

    task automatic test_reset;
        @(negedge CLK);
        #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_f, rsp_c, alu_a, alu_b, alu_s} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%0d id=%0d f=%h c=%0d a=%h b=%h s=%h, expected all 0",
                     rsp_valid, rsp_id, rsp_f, rsp_c, alu_a, alu_b, alu_s);
        end
        tests_run++;
        if ({r0r, r1r, rsp_valid_3} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready: r0r=%0d r1r=%0d rsp_valid_3=%0d, expected 0", r0r, r1r, rsp_valid_3);
        end
        RST = 1'b0;
    endtask

    task automatic test_single;
        step(1'b1, 4'h3, 4'h5, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if ({last_acc, last_id} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_accept: acc=%0d id=%0d, expected acc=1 id=0", last_acc, last_id);
        end
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if ({alu_a, alu_b, alu_s, rsp_valid} !== {4'h3, 4'h5, 4'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_alu_in: a=%h b=%h s=%h valid=%0d, expected a=3 b=5 s=0 valid=0",
                     alu_a, alu_b, alu_s, rsp_valid);
        end
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_f, rsp_c} !== {1'b1, 1'b0, 4'h8, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_rsp: valid=%0d id=%0d f=%h c=%0d, expected valid=1 id=0 f=8 c=0",
                     rsp_valid, rsp_id, rsp_f, rsp_c);
        end
        idle_steps(1);
    endtask

    task automatic test_reset_mid_exec;
        step(1'b1, 4'h3, 4'h5, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if (last_acc !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_exec_accept: acc=%0d, expected 1", last_acc);
        end
        @(negedge CLK);
        r0v = 1'b0;
        RST = 1'b1;
        exp_q.delete();
        ptr_m = 1'b0;
        #1;
        tests_run++;
        if ({alu_a, alu_b, alu_s, rsp_valid} !== 13'd0) begin
            tests_failed++;
            $display("FAIL rst_exec_clear: a=%h b=%h s=%h valid=%0d, expected 0", alu_a, alu_b, alu_s, rsp_valid);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_exec_no_rsp: cycle %0d valid=%0d, expected 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_contention;
        logic [3:0] seq;
        int         n;
        seq = 4'b0;
        n   = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i), 4'(i + 3), 4'(i), 1'b1, 4'(15 - i), 4'(i * 5), 4'(i + 1), 1'b1);
            if (last_acc) begin
                if (n < 4) seq[n] = last_id;
                n++;
            end
        end
        tests_run++;
        if (n !== 4 || seq !== 4'b1010) begin
            tests_failed++;
            $display("FAIL contention_seq: grants=%0d order(bit0 first)=%b, expected 4 grants 0,1,0,1 (1010)", n, seq);
        end
        idle_steps(3);
    endtask

    task automatic test_backpressure;
        logic [5:0]  rsp_snap;
        logic [11:0] alu_snap;
        step(1'b1, 4'h9, 4'h9, 4'h0, 1'b1, 4'h2, 4'h7, 4'h3, 1'b0);
        tests_run++;
        if ({last_acc, last_id} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_accept: acc=%0d id=%0d, expected acc=1 id=0", last_acc, last_id);
        end
        step(1'b1, 4'h9, 4'h9, 4'h0, 1'b1, 4'h2, 4'h7, 4'h3, 1'b0);
        step(1'b1, 4'h9, 4'h9, 4'h0, 1'b1, 4'h2, 4'h7, 4'h3, 1'b0);
        tests_run++;
        if ({rsp_valid, last_acc} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_rsp_rise: valid=%0d acc=%0d, expected valid=1 acc=0", rsp_valid, last_acc);
        end
        rsp_snap = {rsp_valid, rsp_id, rsp_f};
        alu_snap = {alu_a, alu_b, alu_s};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'h9, 4'h9, 4'h0, 1'b1, 4'h2, 4'h7, 4'h3, 1'b0);
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_f} !== rsp_snap || {alu_a, alu_b, alu_s} !== alu_snap || last_acc !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold: cycle %0d rsp=%h alu=%h acc=%0d, expected rsp=%h alu=%h acc=0",
                         i, {rsp_valid, rsp_id, rsp_f}, {alu_a, alu_b, alu_s}, last_acc, rsp_snap, alu_snap);
            end
        end
        step(1'b1, 4'h9, 4'h9, 4'h0, 1'b1, 4'h2, 4'h7, 4'h3, 1'b1);
        tests_run++;
        if ({rsp_valid, last_acc} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_handshake: valid=%0d acc=%0d, expected valid=1 acc=0", rsp_valid, last_acc);
        end
        step(1'b1, 4'h9, 4'h9, 4'h0, 1'b1, 4'h2, 4'h7, 4'h3, 1'b1);
        tests_run++;
        if ({last_acc, last_id, rsp_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL bp_next_accept: acc=%0d id=%0d valid=%0d, expected acc=1 id=1 valid=0",
                     last_acc, last_id, rsp_valid);
        end
        idle_steps(3);
    endtask

    task automatic test_lone;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'(i), 4'(3 * i), 4'(i + 2), 1'b1);
            tests_run++;
            if (last_acc !== (i % 3 == 0)) begin
                tests_failed++;
                $display("FAIL lone_issue: cycle %0d acc=%0d, expected %0d", i, last_acc, (i % 3 == 0));
            end
        end
        idle_steps(3);
    endtask

    task automatic test_latency3;
        @(negedge CLK);
        r0v_3 = 1'b1; r0a_3 = 4'h6; r0b_3 = 4'h2; r0s_3 = 4'h1;
        alu_f_3 = 4'h0; alu_c_3 = 1'b0;
        #1;
        tests_run++;
        if (r0r_3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat3_accept: ready=%0d, expected 1", r0r_3);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            r0v_3 = 1'b0;
            case (i)
                1:       {alu_c_3, alu_f_3} = {1'b1, 4'hA};
                2:       {alu_c_3, alu_f_3} = {1'b0, 4'h5};
                default: {alu_c_3, alu_f_3} = {1'b1, 4'h9};
            endcase
            #1;
            tests_run++;
            if ({rsp_valid_3, alu_a_3, alu_b_3, alu_s_3} !== {1'b0, 4'h6, 4'h2, 4'h1}) begin
                tests_failed++;
                $display("FAIL lat3_exec: cycle %0d valid=%0d a=%h b=%h s=%h, expected valid=0 a=6 b=2 s=1",
                         i, rsp_valid_3, alu_a_3, alu_b_3, alu_s_3);
            end
        end
        @(negedge CLK);
        {alu_c_3, alu_f_3} = 5'h0;
        #1;
        tests_run++;
        if ({rsp_valid_3, rsp_id_3, rsp_f_3, rsp_c_3} !== {1'b1, 1'b0, 4'h9, 1'b1}) begin
            tests_failed++;
            $display("FAIL lat3_capture: valid=%0d id=%0d f=%h c=%0d, expected valid=1 id=0 f=9 c=1",
                     rsp_valid_3, rsp_id_3, rsp_f_3, rsp_c_3);
        end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r0v = 1'b0; r0a = '0; r0b = '0; r0s = '0;
        r1v = 1'b0; r1a = '0; r1b = '0; r1s = '0;
        rsp_ready = 1'b1;
        r0v_3 = 1'b0; r0a_3 = '0; r0b_3 = '0; r0s_3 = '0;
        r1v_3 = 1'b0; r1a_3 = '0; r1b_3 = '0; r1s_3 = '0;
        alu_f_3 = '0; alu_c_3 = 1'b0; rsp_ready_3 = 1'b1;

        test_reset;
        test_single;
        test_reset_mid_exec;
        test_contention;
        test_backpressure;
        test_lone;
        test_latency3;

        #5;
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
